hazard_ctl: RTL and testbench

- Pipeline hazard controller for the 5-stage core (IF, ID, EX, MEM, WB).
- Drives the synchronous clear and hold inputs of the four inter-stage `regr` banks (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC register.
- Resolves four conditions:
  - memory wait;
  - multi-cycle EX ops (vector/divide), tracked by an internal FSM and down-counter;
  - taken-branch flush;
  - load-use interlock.
- Control outputs are combinational from state and inputs, so they are valid before the edge on which the `regr` banks sample them.

---
 rtl/hazard_ctl_pkg.sv | 13 +
 rtl/hazard_ctl_if.sv | 58 +++++
 rtl/hazard_ldu_cmp.sv | 26 ++
 rtl/hazard_ctl.sv | 119 +++++++++++
 tb/tb_hazard_ctl.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/hazard_ctl_pkg.sv
// Shared types and defaults for the pipeline hazard controller.
package hazard_ctl_pkg;

  localparam int unsigned DEF_REG_W = 5;
  localparam int unsigned DEF_MC_W  = 6;
  localparam int unsigned REG_ZERO  = 0;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_MULTI = 1'b1
  } state_t;

endpackage

// File: rtl/hazard_ctl_if.sv
// Hazard-controller bundle: pipeline status in, stage-register controls out.
// Carries the perf counters when HAZARD_PERF_EN is defined.
interface hazard_ctl_if
  import hazard_ctl_pkg::*;
#(
  parameter int unsigned REG_W = DEF_REG_W,
  parameter int unsigned MC_W  = DEF_MC_W
);

  logic [REG_W-1:0] id_rs1;
  logic [REG_W-1:0] id_rs2;
  logic             id_use_rs1;
  logic             id_use_rs2;
  logic             ex_is_load;
  logic [REG_W-1:0] ex_rd;
  logic             mc_start;
  logic [MC_W-1:0]  mc_len;
  logic             br_taken;
  logic             mem_stall;

  logic             hold_pc;
  logic             hold_if_id;
  logic             clear_if_id;
  logic             hold_id_ex;
  logic             clear_id_ex;
  logic             hold_ex_mem;
  logic             clear_ex_mem;
  logic             hold_mem_wb;
  logic             clear_mem_wb;
  logic             mc_busy;
`ifdef HAZARD_PERF_EN
  logic [31:0]      perf_stall_cycles;
  logic [15:0]      perf_flushes;
`endif

  // Pipeline side: reports status, consumes controls.
  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_is_load, ex_rd,
    output mc_start, mc_len, br_taken, mem_stall,
    input  hold_pc, hold_if_id, clear_if_id, hold_id_ex, clear_id_ex,
    input  hold_ex_mem, clear_ex_mem, hold_mem_wb, clear_mem_wb, mc_busy
`ifdef HAZARD_PERF_EN
    , input perf_stall_cycles, perf_flushes
`endif
  );

  // Controller side.
  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_is_load, ex_rd,
    input  mc_start, mc_len, br_taken, mem_stall,
    output hold_pc, hold_if_id, clear_if_id, hold_id_ex, clear_id_ex,
    output hold_ex_mem, clear_ex_mem, hold_mem_wb, clear_mem_wb, mc_busy
`ifdef HAZARD_PERF_EN
    , output perf_stall_cycles, perf_flushes
`endif
  );

endinterface

// File: rtl/hazard_ldu_cmp.sv
// Load-use comparator: flags an ID source that the load in EX has not yet produced.
module hazard_ldu_cmp
  import hazard_ctl_pkg::*;
#(
  parameter int unsigned REG_W = DEF_REG_W
) (
  input  logic [REG_W-1:0] i_id_rs1,
  input  logic [REG_W-1:0] i_id_rs2,
  input  logic             i_use_rs1,
  input  logic             i_use_rs2,
  input  logic             i_ex_is_load,
  input  logic [REG_W-1:0] i_ex_rd,
  output logic             o_hit_c
);

  logic w_rd_live;
  logic w_rs1_hit;
  logic w_rs2_hit;

  // Writes to the zero register never create a dependency.
  assign w_rd_live = i_ex_is_load && (i_ex_rd != REG_W'(REG_ZERO));
  assign w_rs1_hit = i_use_rs1 && (i_id_rs1 == i_ex_rd);
  assign w_rs2_hit = i_use_rs2 && (i_id_rs2 == i_ex_rd);
  assign o_hit_c   = w_rd_live && (w_rs1_hit || w_rs2_hit);

endmodule

// File: rtl/hazard_ctl.sv
// Pipeline hazard controller: memory wait, multi-cycle EX, branch flush and
// load-use interlock for the 5-stage core. Controls are combinational so the
// stage registers see them before the capturing edge.
// Optional: define HAZARD_PERF_EN for stall-cycle and flush counters.
module hazard_ctl
  import hazard_ctl_pkg::*;
#(
  parameter int unsigned REG_W = DEF_REG_W,
  parameter int unsigned MC_W  = DEF_MC_W
) (
  input  logic         clk,
  input  logic         reset,
  hazard_ctl_if.slave  hz
);

  state_t          r_state;
  logic [MC_W-1:0] r_cnt;
  logic            w_len_ge2;
  logic            w_mc_stall;
  logic            w_br_flush;
  logic            w_ldu_hit;

  hazard_ldu_cmp #(.REG_W(REG_W)) u_ldu_cmp (
    .i_id_rs1     (hz.id_rs1),
    .i_id_rs2     (hz.id_rs2),
    .i_use_rs1    (hz.id_use_rs1),
    .i_use_rs2    (hz.id_use_rs2),
    .i_ex_is_load (hz.ex_is_load),
    .i_ex_rd      (hz.ex_rd),
    .o_hit_c      (w_ldu_hit)
  );

  assign w_len_ge2  = hz.mc_len >= MC_W'(2);
  assign w_mc_stall = ((r_state == ST_RUN) && hz.mc_start && w_len_ge2) ||
                      ((r_state == ST_MULTI) && (r_cnt != '0));
  // Flush only when nothing above it in priority is active.
  assign w_br_flush = !reset && !hz.mem_stall && !w_mc_stall &&
                      (r_state == ST_RUN) && hz.br_taken;

  // Multi-cycle FSM; everything freezes while memory is stalled.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_RUN;
      r_cnt   <= '0;
    end else if (!hz.mem_stall) begin
      case (r_state)
        ST_RUN: begin
          if (hz.mc_start && w_len_ge2) begin
            r_state <= ST_MULTI;
            r_cnt   <= hz.mc_len - MC_W'(2);
          end
        end
        ST_MULTI: begin
          if (r_cnt != '0) r_cnt <= r_cnt - MC_W'(1);
          else             r_state <= ST_RUN;
        end
      endcase
    end
  end

  // Priority mux: reset > mem wait > multi-cycle > branch > load-use.
  always_comb begin
    hz.hold_pc      = 1'b0;
    hz.hold_if_id   = 1'b0;
    hz.clear_if_id  = 1'b0;
    hz.hold_id_ex   = 1'b0;
    hz.clear_id_ex  = 1'b0;
    hz.hold_ex_mem  = 1'b0;
    hz.clear_ex_mem = 1'b0;
    hz.hold_mem_wb  = 1'b0;
    hz.clear_mem_wb = 1'b0;
    hz.mc_busy      = !reset && (r_state == ST_MULTI);
    if (reset) begin
      hz.hold_pc      = 1'b1;
      hz.clear_if_id  = 1'b1;
      hz.clear_id_ex  = 1'b1;
      hz.clear_ex_mem = 1'b1;
      hz.clear_mem_wb = 1'b1;
    end else if (hz.mem_stall) begin
      hz.hold_pc      = 1'b1;
      hz.hold_if_id   = 1'b1;
      hz.hold_id_ex   = 1'b1;
      hz.hold_ex_mem  = 1'b1;
      hz.clear_mem_wb = 1'b1;
    end else if (w_mc_stall) begin
      hz.hold_pc      = 1'b1;
      hz.hold_if_id   = 1'b1;
      hz.hold_id_ex   = 1'b1;
      hz.clear_ex_mem = 1'b1;
    end else if (w_br_flush) begin
      hz.clear_if_id  = 1'b1;
      hz.clear_id_ex  = 1'b1;
    end else if (w_ldu_hit) begin
      hz.hold_pc      = 1'b1;
      hz.hold_if_id   = 1'b1;
      hz.clear_id_ex  = 1'b1;
    end
  end

`ifdef HAZARD_PERF_EN
  logic [31:0] r_perf_stall;
  logic [15:0] r_perf_flush;

  // Free-running wrap-around counters of PC-hold cycles and applied flushes.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_perf_stall <= '0;
      r_perf_flush <= '0;
    end else begin
      if (hz.hold_pc) r_perf_stall <= r_perf_stall + 32'd1;
      if (w_br_flush) r_perf_flush <= r_perf_flush + 16'd1;
    end
  end

  assign hz.perf_stall_cycles = r_perf_stall;
  assign hz.perf_flushes      = r_perf_flush;
`endif

endmodule

// File: tb/tb_hazard_ctl.sv
// Scoreboard bench for hazard_ctl: the driver pushes model expectations per
// cycle, a negedge monitor pops and compares against the DUT controls.
module tb_hazard_ctl;
  import hazard_ctl_pkg::*;

  typedef struct packed {
    logic hold_pc;
    logic hold_if_id;
    logic clear_if_id;
    logic hold_id_ex;
    logic clear_id_ex;
    logic hold_ex_mem;
    logic clear_ex_mem;
    logic hold_mem_wb;
    logic clear_mem_wb;
    logic mc_busy;
  } ctl_t;

  typedef struct packed {
    ctl_t        ctl;
    logic        chk_perf;
    logic [31:0] ps;
    logic [15:0] pf;
  } exp_t;

  logic clk = 1'b0;
  logic reset;

  hazard_ctl_if hz ();

  hazard_ctl dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hz)
  );

  always #5 clk = ~clk;

  exp_t  exp_q[$];
  string tag_q[$];
  int    n_tests = 0;
  int    n_fail  = 0;
  int    obs_mc  = 0;
  int    obs_ms  = 0;

  // Reference model state.
  bit          m_multi = 1'b0;
  int          m_left  = 0;
  logic [31:0] m_ps    = '0;
  logic [15:0] m_pf    = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic ctl_t model_ctl();
    ctl_t c;
    bit   mcs;
    bit   ldu;
    c   = '0;
    mcs = (!m_multi && hz.mc_start && (hz.mc_len >= 2)) || (m_multi && (m_left > 0));
    ldu = hz.ex_is_load && (hz.ex_rd != 0) &&
          ((hz.id_use_rs1 && (hz.id_rs1 == hz.ex_rd)) ||
           (hz.id_use_rs2 && (hz.id_rs2 == hz.ex_rd)));
    if (reset) begin
      c.hold_pc = 1; c.clear_if_id = 1; c.clear_id_ex = 1;
      c.clear_ex_mem = 1; c.clear_mem_wb = 1;
    end else begin
      c.mc_busy = m_multi;
      if (hz.mem_stall) begin
        c.hold_pc = 1; c.hold_if_id = 1; c.hold_id_ex = 1;
        c.hold_ex_mem = 1; c.clear_mem_wb = 1;
      end else if (mcs) begin
        c.hold_pc = 1; c.hold_if_id = 1; c.hold_id_ex = 1; c.clear_ex_mem = 1;
      end else if (!m_multi && hz.br_taken) begin
        c.clear_if_id = 1; c.clear_id_ex = 1;
      end else if (ldu) begin
        c.hold_pc = 1; c.hold_if_id = 1; c.clear_id_ex = 1;
      end
    end
    return c;
  endfunction

  // One clock cycle: record expectation, advance model, wait for the edge.
  task automatic step(input string tag);
    ctl_t c;
    exp_t e;
    c          = model_ctl();
    e.ctl      = c;
    e.chk_perf = !reset;
    e.ps       = m_ps;
    e.pf       = m_pf;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    if (reset) begin
      m_multi = 0; m_left = 0; m_ps = '0; m_pf = '0;
    end else begin
      if (c.hold_pc)     m_ps = m_ps + 32'd1;
      if (c.clear_if_id) m_pf = m_pf + 16'd1;
      if (!hz.mem_stall) begin
        if (!m_multi) begin
          if (hz.mc_start && (hz.mc_len >= 2)) begin
            m_multi = 1;
            m_left  = int'(hz.mc_len) - 2;
          end
        end else if (m_left > 0) begin
          m_left--;
        end else begin
          m_multi = 0;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    hz.id_rs1 = '0; hz.id_rs2 = '0; hz.id_use_rs1 = 0; hz.id_use_rs2 = 0;
    hz.ex_is_load = 0; hz.ex_rd = '0; hz.mc_start = 0; hz.mc_len = '0;
    hz.br_taken = 0; hz.mem_stall = 0;
  endtask

  exp_t  mon_e;
  ctl_t  mon_got;
  string mon_tag;

  // Monitor: compare mid-cycle, away from the capturing edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e   = exp_q.pop_front();
      mon_tag = tag_q.pop_front();
      mon_got = {hz.hold_pc, hz.hold_if_id, hz.clear_if_id, hz.hold_id_ex,
                 hz.clear_id_ex, hz.hold_ex_mem, hz.clear_ex_mem,
                 hz.hold_mem_wb, hz.clear_mem_wb, hz.mc_busy};
      check(mon_tag, 64'(mon_got), 64'(mon_e.ctl));
      if (mon_got.hold_pc && mon_got.clear_ex_mem && !mon_got.hold_ex_mem) obs_mc++;
      if (mon_got.hold_ex_mem && mon_got.clear_mem_wb) obs_ms++;
`ifdef HAZARD_PERF_EN
      if (mon_e.chk_perf)
        check({mon_tag, "_perf"}, 64'({hz.perf_stall_cycles, hz.perf_flushes}),
              64'({mon_e.ps, mon_e.pf}));
`endif
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    idle();
    @(posedge clk);
    #1;
    repeat (3) step("rst");
    reset = 1'b0;
    step("post_rst");

    // Load-use interlock variants.
    hz.ex_is_load = 1; hz.ex_rd = 5'd5; hz.id_rs2 = 5'd5; hz.id_use_rs2 = 1;
    hz.id_rs1 = 5'd3; hz.id_use_rs1 = 1;
    step("ldu_rs2");
    hz.ex_is_load = 0; hz.ex_rd = 5'd0;
    step("ldu_bubble");
    idle();
    hz.ex_is_load = 1; hz.ex_rd = 5'd0; hz.id_rs2 = 5'd0; hz.id_use_rs2 = 1;
    step("ldu_x0");
    hz.ex_rd = 5'd7; hz.id_rs1 = 5'd7; hz.id_use_rs1 = 1; hz.id_rs2 = 5'd1;
    step("ldu_rs1");
    hz.id_use_rs1 = 0;
    step("ldu_nouse");
    hz.ex_is_load = 0; hz.id_use_rs1 = 1;
    step("ldu_noload");

    // Multi-cycle op of length 4: three stall cycles then release.
    idle();
    obs_mc = 0;
    hz.mc_start = 1; hz.mc_len = 6'd4;
    repeat (4) step("mc4");
    hz.mc_start = 0;
    step("mc4_done");
    check("mc4_stalls", 64'(obs_mc), 64'd3);

    // Short lengths never stall.
    obs_mc = 0;
    hz.mc_start = 1; hz.mc_len = 6'd1;
    step("mc1");
    hz.mc_len = 6'd0;
    step("mc0");
    hz.mc_start = 0;
    step("mc_idle");
    check("mc1_stalls", 64'(obs_mc), 64'd0);

    // Memory wait in the middle of a multi-cycle op.
    obs_mc = 0; obs_ms = 0;
    hz.mc_start = 1; hz.mc_len = 6'd4;
    for (int i = 0; i < 6; i++) begin
      hz.mem_stall = (i == 2) || (i == 3);
      step("mc4_ms");
    end
    hz.mc_start = 0; hz.mem_stall = 0;
    step("mc4_ms_done");
    check("mc4_ms_stalls", 64'(obs_mc), 64'd3);
    check("mc4_ms_memcyc", 64'(obs_ms), 64'd2);

    // Branch flush, masked by memory wait, and winning over load-use.
    hz.br_taken = 1;
    step("br");
    hz.mem_stall = 1;
    step("br_ms");
    hz.mem_stall = 0;
    hz.ex_is_load = 1; hz.ex_rd = 5'd9; hz.id_rs1 = 5'd9; hz.id_use_rs1 = 1;
    step("br_ldu");
    idle();
    step("br_idle");

    // Mixed random traffic (branch never paired with mc_start).
    for (int i = 0; i < 60; i++) begin
      hz.mem_stall  = ($urandom_range(0, 3) == 0);
      hz.mc_start   = ($urandom_range(0, 3) == 0);
      hz.mc_len     = 6'($urandom_range(0, 5));
      hz.br_taken   = !hz.mc_start && ($urandom_range(0, 4) == 0);
      hz.ex_is_load = ($urandom_range(0, 1) == 1);
      hz.ex_rd      = 5'($urandom_range(0, 3));
      hz.id_rs1     = 5'($urandom_range(0, 3));
      hz.id_rs2     = 5'($urandom_range(0, 3));
      hz.id_use_rs1 = ($urandom_range(0, 1) == 1);
      hz.id_use_rs2 = ($urandom_range(0, 1) == 1);
      step("rand");
    end
    idle();
    repeat (6) step("drain");

    // Reset in the middle of a multi-cycle op aborts it.
    hz.mc_start = 1; hz.mc_len = 6'd5;
    step("mc5_start");
    step("mc5_multi");
    reset = 1'b1;
    step("rst_multi");
    reset = 1'b0;
    hz.mc_start = 0;
    step("post_rst_multi");
    step("post_rst_idle");

    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
